branch_resolve: RTL and testbench

//  Resolution end of the fetch-side branch target buffer. Queues each fetch-stage prediction in order,

---
 rtl/branch_resolve.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolution end of the fetch-side branch target buffer. Fetch pushes one
//   prediction per issued instruction. Writeback pops the queue head and
//   compares the predicted next PC with the actual next PC. A mismatch raises
//   a one-cycle flush with a redirect PC, clears the queue, and squashes
//   FLUSH_CYCLES further cycles. Taken control-flow instructions produce a
//   one-cycle BTB write request. Saturating counters track resolved
//   control-flow instructions and mispredicts.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   pred_valid/pc/taken/target  push side (fetch)
//   res_valid/pc/opcode/taken/target  pop side (writeback)
//   q_full                    queue holds DEPTH entries
//   flush, redirect_pc        one-cycle squash pulse and correct next PC
//   upd_valid/pc/target       one-cycle BTB write request
//   sync_err                  sticky push/pop ordering error
//   branch_count, mispredict_count  saturating statistics
module branch_resolve #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid,
  input  logic [15:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [15:0]      pred_target,
  input  logic             res_valid,
  input  logic [15:0]      res_pc,
  input  logic [3:0]       res_opcode,
  input  logic             res_taken,
  input  logic [15:0]      res_target,
  output logic             q_full,
  output logic             flush,
  output logic [15:0]      redirect_pc,
  output logic             upd_valid,
  output logic [15:0]      upd_pc,
  output logic [15:0]      upd_target,
  output logic             sync_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  // Prediction storage (no reset needed: validity is carried by count)
  logic [15:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [15:0] target_mem [DEPTH];

  state_t           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             q_full_q, flush_q, flush_d, upd_valid_q, upd_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [15:0]      redirect_q, redirect_d, upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic        run, resolve, is_cf, sync_bad, pop, mispred, push_try, push_ok;
  logic [15:0] head_pc, head_target, pred_next, act_next;
  logic        head_taken;

  assign head_pc     = pc_mem[head_q];
  assign head_taken  = taken_mem[head_q];
  assign head_target = target_mem[head_q];

  always_comb begin
    run       = (state_q == S_RUN);
    resolve   = run && res_valid;
    is_cf     = (res_opcode == OP_BR) || (res_opcode == OP_JSR) ||
                (res_opcode == OP_JMP) || (res_opcode == OP_TRAP);
    // Non-control-flow opcodes always fall through, whatever res_taken says
    act_next  = (is_cf && res_taken) ? res_target : res_pc + 16'd2;
    pred_next = head_taken ? head_target : head_pc + 16'd2;
    sync_bad  = resolve && ((count_q == '0) || (head_pc != res_pc));
    pop       = resolve && !sync_bad;
    mispred   = sync_bad || (pop && (pred_next != act_next));
    push_try  = run && pred_valid && !mispred;
    // A same-cycle pop frees the slot, so a push at full is still accepted
    push_ok   = push_try && ((count_q != FULL_CNT) || pop);

    state_d      = state_q;
    fcnt_d       = fcnt_q;
    head_d       = head_q + PW'(pop);
    tail_d       = tail_q + PW'(push_ok);
    count_d      = count_q + CW'(push_ok) - CW'(pop);
    flush_d      = mispred;
    redirect_d   = mispred ? act_next : '0;
    upd_valid_d  = resolve && is_cf && res_taken;
    upd_pc_d     = upd_valid_d ? res_pc : '0;
    upd_target_d = upd_valid_d ? res_target : '0;
    sync_err_d   = sync_err_q || sync_bad || (push_try && !push_ok);
    bcnt_d       = bcnt_q;
    mcnt_d       = mcnt_q;

    if (resolve && is_cf && (bcnt_q != '1)) bcnt_d = bcnt_q + 1'b1;

    if (run) begin
      if (mispred) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = S_FLUSH;
        fcnt_d  = FLUSH_INIT;
        if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
      end
    end else begin
      fcnt_d = fcnt_q - 1'b1;
      if (fcnt_q <= FCW'(1)) begin
        state_d = S_RUN;
        fcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail_q]     <= pred_pc;
      taken_mem[tail_q]  <= pred_taken;
      target_mem[tail_q] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      fcnt_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      q_full_q     <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      sync_err_q   <= 1'b0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      // Registered from the next count so it always agrees with count_q
      q_full_q     <= (count_d == FULL_CNT);
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      sync_err_q   <= sync_err_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
    end
  end

  assign q_full           = q_full_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign upd_valid        = upd_valid_q;
  assign upd_pc           = upd_pc_q;
  assign upd_target       = upd_target_q;
  assign sync_err         = sync_err_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int DEPTH        = 8;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pred_valid, pred_taken, res_valid, res_taken;
  logic [15:0]      pred_pc, pred_target, res_pc, res_target;
  logic [3:0]       res_opcode;
  logic             q_full, flush, upd_valid, sync_err;
  logic [15:0]      redirect_pc, upd_pc, upd_target;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolve #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_opcode       (res_opcode),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .q_full           (q_full),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .sync_err         (sync_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-order list of outstanding predictions plus the
  // number of squashed cycles still to come after a mispredict.
  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
    logic [15:0] tgt;
  } ent_t;

  ent_t             mq[$];
  int               ign;
  logic             e_flush, e_upd, e_serr;
  logic [15:0]      e_redir, e_upc, e_utg;
  logic [CNT_W-1:0] e_bcnt, e_mcnt;

  task automatic model_reset();
    mq.delete();
    ign = 0;
    e_flush = 0; e_upd = 0; e_serr = 0;
    e_redir = 0; e_upc = 0; e_utg = 0;
    e_bcnt = 0; e_mcnt = 0;
  endtask

  task automatic model_step(input logic pv, input logic [15:0] ppc, input logic pt,
                            input logic [15:0] ptg, input logic rv, input logic [15:0] rpc,
                            input logic [3:0] rop, input logic rt, input logic [15:0] rtg);
    logic        cf, mis;
    logic [15:0] act, pn;
    ent_t        e;
    e_flush = 0; e_upd = 0; e_redir = 0; e_upc = 0; e_utg = 0;
    mis = 0;
    if (ign > 0) begin
      ign--;
    end else begin
      if (rv) begin
        cf  = (rop == 4'h0) || (rop == 4'h4) || (rop == 4'hC) || (rop == 4'hF);
        act = (cf && rt) ? rtg : 16'(rpc + 16'd2);
        if (mq.size() == 0 || mq[0].pc != rpc) begin
          e_serr = 1; mis = 1;
        end else begin
          e  = mq.pop_front();
          pn = e.taken ? e.tgt : 16'(e.pc + 16'd2);
          if (pn != act) mis = 1;
        end
        if (cf) begin
          if (e_bcnt != '1) e_bcnt = e_bcnt + 1'b1;
          if (rt) begin e_upd = 1; e_upc = rpc; e_utg = rtg; end
        end
        if (mis) begin
          if (e_mcnt != '1) e_mcnt = e_mcnt + 1'b1;
          e_flush = 1; e_redir = act;
          mq.delete();
          ign = FLUSH_CYCLES;
        end
      end
      if (pv && !mis) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: ppc, taken: pt, tgt: ptg});
        else e_serr = 1;
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge
  task automatic cyc(input logic pv, input logic [15:0] ppc, input logic pt,
                     input logic [15:0] ptg, input logic rv, input logic [15:0] rpc,
                     input logic [3:0] rop, input logic rt, input logic [15:0] rtg);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_opcode = rop; res_taken = rt; res_target = rtg;
    model_step(pv, ppc, pt, ptg, rv, rpc, rop, rt, rtg);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_pc = 0; res_opcode = 0; res_taken = 0; res_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({flush, upd_valid, sync_err, q_full} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {flush, upd_valid, sync_err, q_full});
    end
    checks++;
    if (branch_count !== '0 || mispredict_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %h/%h expected 0/0", branch_count, mispredict_count);
    end
    checks++;
    if ({redirect_pc, upd_pc, upd_target} !== 48'h0) begin
      errors++;
      $display("FAIL reset_pcs: got %h %h %h expected 0", redirect_pc, upd_pc, upd_target);
    end
  endtask

  task automatic test_not_taken();
    cyc(1, 16'h3000, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h3000, 4'b0001, 0, 16'h0);
    checks++;
    if (flush !== 1'b0 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL nt_pulses: got flush=%b upd=%b expected 0 0", flush, upd_valid);
    end
    checks++;
    if (branch_count !== 16'd0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL nt_state: got bcnt=%0d serr=%b expected 0 0", branch_count, sync_err);
    end
  endtask

  task automatic test_taken_update();
    cyc(1, 16'h3002, 1, 16'h3010, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h3002, 4'b0000, 1, 16'h3010);
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL tk_flush: got %b expected 0", flush);
    end
    checks++;
    if ({upd_valid, upd_pc, upd_target} !== {1'b1, 16'h3002, 16'h3010}) begin
      errors++;
      $display("FAIL tk_upd: got %b %h %h expected 1 3002 3010", upd_valid, upd_pc, upd_target);
    end
    checks++;
    if (branch_count !== 16'd1) begin
      errors++;
      $display("FAIL tk_bcnt: got %0d expected 1", branch_count);
    end
    idle();
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL tk_upd_pulse: got %b expected 0", upd_valid);
    end
  endtask

  task automatic test_mispredict();
    cyc(1, 16'h3004, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h3004, 4'b0000, 1, 16'h3020);
    checks++;
    if ({flush, redirect_pc} !== {1'b1, 16'h3020}) begin
      errors++;
      $display("FAIL mp_redirect: got %b %h expected 1 3020", flush, redirect_pc);
    end
    checks++;
    if (mispredict_count !== 16'd1 || branch_count !== 16'd2) begin
      errors++;
      $display("FAIL mp_counts: got m=%0d b=%0d expected 1 2", mispredict_count, branch_count);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'(16'h4000 + 2 * i), 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL mp_squash%0d: got flush=%b expected 0", i, flush);
      end
    end
    cyc(1, 16'h5000, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h5000, 4'b0001, 0, 16'h0);
    checks++;
    if (flush !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL mp_after: got flush=%b serr=%b expected 0 0", flush, sync_err);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'(16'h6000 + 2 * i), 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
      if (i == 6) begin
        checks++;
        if (q_full !== 1'b0) begin
          errors++;
          $display("FAIL full_at7: got %b expected 0", q_full);
        end
      end
    end
    checks++;
    if (q_full !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL full_at8: got full=%b serr=%b expected 1 0", q_full, sync_err);
    end
    cyc(1, 16'h6100, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    checks++;
    if (q_full !== 1'b1 || sync_err !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: got full=%b serr=%b expected 1 1", q_full, sync_err);
    end
    cyc(1, 16'h7000, 0, 16'h0, 1, 16'h6000, 4'b0001, 0, 16'h0);
    checks++;
    if (q_full !== 1'b1 || flush !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: got full=%b flush=%b expected 1 0", q_full, flush);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] rp;
      rp = (i < 7) ? 16'(16'h6002 + 2 * i) : 16'h7000;
      cyc(0, 16'h0, 0, 16'h0, 1, rp, 4'b0001, 0, 16'h0);
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL full_drain%0d: got flush=%b expected 0", i, flush);
      end
    end
    checks++;
    if (q_full !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got %b expected 0", q_full);
    end
  endtask

  task automatic test_wrap();
    cyc(1, 16'hFFFE, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'hFFFE, 4'b1100, 0, 16'h0);
    checks++;
    if (flush !== 1'b0 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulses: got flush=%b upd=%b expected 0 0", flush, upd_valid);
    end
    checks++;
    if (branch_count !== 16'd3 || mispredict_count !== 16'd1) begin
      errors++;
      $display("FAIL wrap_counts: got b=%0d m=%0d expected 3 1", branch_count, mispredict_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] cfl [4];
    cfl[0] = 4'h0; cfl[1] = 4'h4; cfl[2] = 4'hC; cfl[3] = 4'hF;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        pv, pt, rv, rt;
      logic [15:0] ppc, ptg, rpc, rtg;
      logic [3:0]  rop;
      pv  = ($urandom_range(0, 99) < 55);
      ppc = 16'($urandom) & 16'hFFFE;
      pt  = 1'($urandom_range(0, 1));
      ptg = 16'($urandom) & 16'hFFFE;
      rv  = ($urandom_range(0, 99) < 50);
      rpc = 16'($urandom) & 16'hFFFE;
      rop = 4'($urandom);
      rt  = 1'($urandom_range(0, 1));
      rtg = 16'($urandom) & 16'hFFFE;
      if (rv && mq.size() > 0 && $urandom_range(0, 99) < 90) begin
        rpc = mq[0].pc;
        if ($urandom_range(0, 99) < 80) begin
          if (mq[0].taken) begin
            rop = cfl[$urandom_range(0, 3)];
            rt  = 1;
            rtg = mq[0].tgt;
          end else begin
            rt = 0;
          end
        end
      end
      cyc(pv, ppc, pt, ptg, rv, rpc, rop, rt, rtg);
      checks++;
      if (flush !== e_flush) begin
        errors++;
        $display("FAIL rnd_flush@%0d: got %b expected %b", n, flush, e_flush);
      end
      if (e_flush) begin
        checks++;
        if (redirect_pc !== e_redir) begin
          errors++;
          $display("FAIL rnd_redirect@%0d: got %h expected %h", n, redirect_pc, e_redir);
        end
      end
      checks++;
      if (upd_valid !== e_upd) begin
        errors++;
        $display("FAIL rnd_upd@%0d: got %b expected %b", n, upd_valid, e_upd);
      end
      if (e_upd) begin
        checks++;
        if (upd_pc !== e_upc || upd_target !== e_utg) begin
          errors++;
          $display("FAIL rnd_upd_data@%0d: got %h %h expected %h %h", n, upd_pc, upd_target, e_upc, e_utg);
        end
      end
      checks++;
      if (sync_err !== e_serr || q_full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL rnd_status@%0d: got serr=%b full=%b expected %b %b", n, sync_err, q_full,
                 e_serr, (mq.size() == DEPTH));
      end
      checks++;
      if (branch_count !== e_bcnt || mispredict_count !== e_mcnt) begin
        errors++;
        $display("FAIL rnd_counts@%0d: got %0d %0d expected %0d %0d", n, branch_count,
                 mispredict_count, e_bcnt, e_mcnt);
      end
    end
  endtask

  task automatic test_reset_during_flush();
    do_reset();
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h1234, 4'b0000, 1, 16'h2000);
    checks++;
    if ({sync_err, flush, redirect_pc, upd_valid} !== {1'b1, 1'b1, 16'h2000, 1'b1}) begin
      errors++;
      $display("FAIL rf_flush: got serr=%b flush=%b redir=%h upd=%b expected 1 1 2000 1",
               sync_err, flush, redirect_pc, upd_valid);
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    checks++;
    if ({q_full, flush, redirect_pc, upd_valid, upd_pc, upd_target, sync_err,
         branch_count, mispredict_count} !== '0) begin
      errors++;
      $display("FAIL rf_async: got flush=%b upd=%b serr=%b b=%0d m=%0d redir=%h expected all 0",
               flush, upd_valid, sync_err, branch_count, mispredict_count, redirect_pc);
    end
    @(posedge clk);
    #1 reset_n = 1;
    cyc(1, 16'h3000, 0, 16'h0, 0, 16'h0, 4'h0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 1, 16'h3000, 4'b0001, 0, 16'h0);
    checks++;
    if (flush !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL rf_resume: got flush=%b serr=%b expected 0 0", flush, sync_err);
    end
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_taken_update();
    test_mispredict();
    test_full();
    test_wrap();
    test_random();
    test_reset_during_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
